// File: rtl/fifo_level.sv
// fifo_level: first-word-fall-through ready/valid FIFO with occupancy, threshold flags, flush and high watermark
module fifo_level #(
    parameter int DEPTH_W       = 5,
    parameter int DATA_W        = 8,
    parameter int AFULL_THRESH  = 2**DEPTH_W - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               flush,
    input  logic [DATA_W-1:0]  a_data,
    input  logic               a_valid,
    output logic               a_ready,
    output logic [DATA_W-1:0]  b_data,
    output logic               b_valid,
    input  logic               b_ready,
    output logic [DEPTH_W:0]   count,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [DEPTH_W:0]   high_water
);
    localparam int DEPTH = 2**DEPTH_W;
    localparam int CW = DEPTH_W + 1;
    localparam int PW = DEPTH_W > 0 ? DEPTH_W : 1;
    localparam logic [DEPTH_W:0] FULL = CW'(DEPTH);
    localparam logic [DEPTH_W:0] AF = CW'(AFULL_THRESH);
    localparam logic [DEPTH_W:0] AE = CW'(AEMPTY_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [DEPTH_W:0]  count_nxt, hw_nxt;
    logic              push, pop;

    // Handshakes, flags and next-state values; a single-entry FIFO keeps its pointers pinned at 0
    always_comb begin
        a_ready      = (count != FULL) & ~flush & ~nrst;
        b_valid      = (count != '0) & ~flush & ~nrst;
        push         = a_valid & a_ready;
        pop          = b_valid & b_ready;
        b_data       = b_valid ? mem[rd_ptr] : '0;
        almost_full  = ~nrst & (count >= AF);
        almost_empty = nrst | (count <= AE);
        rd_nxt       = (DEPTH_W == 0) ? '0 : rd_ptr + 1'b1;
        wr_nxt       = (DEPTH_W == 0) ? '0 : wr_ptr + 1'b1;
        count_nxt    = (push & ~pop) ? count + 1'b1 : (pop & ~push) ? count - 1'b1 : count;
        hw_nxt       = (count_nxt > high_water) ? count_nxt : high_water;
    end

    // Pointer, occupancy and watermark registers; reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (nrst || flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            high_water <= '0;
        end else begin
            if (push) wr_ptr <= wr_nxt;
            if (pop) rd_ptr <= rd_nxt;
            count      <= count_nxt;
            high_water <= hw_nxt;
        end
    end

    // Payload storage is deliberately not reset; push is already gated by reset and flush
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= a_data;
    end
endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: randomized and directed scoreboard bench for fifo_level against a queue-based model
module tb_fifo_level;
    logic       clk = 1'b0;
    logic       nrst, flush, a_valid, b_ready;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_valid, almost_full, almost_empty;
    logic [2:0] count, high_water;

    int total = 0;
    int bad = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int hw = 0;
    bit mon_en = 0;

    fifo_level #(.DEPTH_W(2), .DATA_W(8), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut (
        .clk(clk), .nrst(nrst), .flush(flush),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
        .high_water(high_water)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model
    task automatic cyc(input bit r, input bit f, input bit v, input logic [7:0] d, input bit br);
        bit ok_w, ok_r, p_push, p_pop;
        logic [7:0] bd;
        @(negedge clk);
        nrst = r; flush = f; a_valid = v; a_data = d; b_ready = br;
        #1;
        ok_w = !r && !f && mq.size() < 4;
        ok_r = !r && !f && mq.size() > 0;
        p_push = ok_w && v;
        p_pop = ok_r && br;
        bd = ok_r ? mq[0] : 8'h00;
        chk("a_ready", 32'(a_ready), 32'(ok_w));
        chk("b_valid", 32'(b_valid), 32'(ok_r));
        chk("b_data_head", 32'(b_data), 32'(bd));
        chk("count", 32'(count), 32'(mq.size()));
        chk("almost_full", 32'(almost_full), 32'(!r && mq.size() >= 3));
        chk("almost_empty", 32'(almost_empty), 32'(r || mq.size() <= 1));
        chk("high_water", 32'(high_water), 32'(hw));
        if (r || f) begin
            mq.delete();
            exp_q.delete();
            hw = 0;
        end else begin
            if (p_pop) void'(mq.pop_front());
            if (p_push) begin
                mq.push_back(d);
                exp_q.push_back(d);
            end
            if (mq.size() > hw) hw = mq.size();
        end
    endtask

    // Monitor: every accepted pop must deliver the oldest word still owed by the scoreboard
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && b_valid === 1'b1 && b_ready === 1'b1) begin
                if (exp_q.size() == 0) chk("pop_unexpected", 32'(b_data), 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("b_data_order", 32'(b_data), 32'(e));
                end
            end
        end
    end

    initial begin
        nrst = 1; flush = 0; a_valid = 0; a_data = 0; b_ready = 0;
        repeat (2) @(negedge clk);
        mon_en = 1;
        cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 1, 8'h11, 0);
        cyc(0, 0, 1, 8'h22, 0);
        cyc(0, 0, 1, 8'h33, 0);
        cyc(0, 0, 1, 8'h44, 0);
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 1, 8'h55, 1);
        cyc(0, 0, 1, 8'h55, 0);
        repeat (5) cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 1, 8'h00, 0);
        for (int i = 1; i < 20; i++) cyc(0, 0, 1, 8'(i), 1);
        repeat (2) cyc(0, 0, 0, 8'h00, 1);
        cyc(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'(8'hA0 + i), 0);
        cyc(0, 1, 1, 8'hA5, 0);
        cyc(0, 0, 1, 8'hA5, 0);
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 1, 8'hB0, 0);
        cyc(0, 0, 1, 8'hB1, 0);
        cyc(1, 0, 1, 8'hB2, 1);
        cyc(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 9) < 6, 8'($urandom_range(0, 255)), $urandom_range(0, 9) < 5);
        repeat (6) cyc(0, 0, 0, 8'h00, 1);
        @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
